// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int unsigned n = 32
) (
  input  logic         is_div,
  input  logic [n-1:0] acc,
  input  logic [n-1:0] q,
  input  logic [n-1:0] m,
  output logic [n-1:0] acc_nx,
  output logic [n-1:0] q_nx
);

  logic [n:0] sum;
  logic [n:0] shifted;
  logic [n:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, m};
    shifted = {acc, q[n-1]};
    trial   = shifted - {1'b0, m};
    acc_nx  = acc;
    q_nx    = q;
    if (is_div) begin
      // remainder stays below the divisor, so the trial difference fits in n bits
      if (shifted >= {1'b0, m}) begin
        acc_nx = trial[n-1:0];
        q_nx   = {q[n-2:0], 1'b1};
      end else begin
        acc_nx = shifted[n-1:0];
        q_nx   = {q[n-2:0], 1'b0};
      end
    end else if (q[0]) begin
      {acc_nx, q_nx} = {sum, q[n-1:1]};
    end else begin
      {acc_nx, q_nx} = {1'b0, acc, q[n-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Define MULDIV_SIGNED_EN to honour op[0] (signed ops); otherwise all ops are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [n-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] hi,
  output logic [n-1:0] lo
);

  localparam int unsigned CW = $clog2(n);

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  state_t        state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  acc, q, m;
  logic [n-1:0]  acc_nx, q_nx;
  logic          is_div, neg_q, neg_r, dz;

  logic          a_neg, b_neg;
  logic [n-1:0]  a_mag, b_mag;

  assign a_neg = SIGNED_EN & op[0] & a[n-1];
  assign b_neg = SIGNED_EN & op[0] & b[n-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  muldiv_step #(.n(n)) u_step (
    .is_div (is_div),
    .acc    (acc),
    .q      (q),
    .m      (m),
    .acc_nx (acc_nx),
    .q_nx   (q_nx)
  );

  // Divide-by-zero leaves |a| in the remainder, so the dividend-sign fixup restores a itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= (b == '0);
            acc    <= '0;
            q      <= op[1] ? a_mag : b_mag;
            m      <= op[1] ? b_mag : a_mag;
            cnt    <= CW'(n - 1);
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        CALC: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            hi <= neg_r ? -acc : acc;
            lo <= dz ? '1 : (neg_q ? -q : q);
          end else begin
            {hi, lo} <= neg_q ? -{acc, q} : {acc, q};
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (expectations track MULDIV_SIGNED_EN).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wr_data;
  logic        wr_hi, wr_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] MULT_HI = 32'hFFFFFFFF;
  localparam logic [31:0] DIV_Q   = 32'hFFFFFFFD;
  localparam logic [31:0] DIV_R   = 32'hFFFFFFFF;
  localparam logic [31:0] MN_Q    = 32'h80000000;
  localparam logic [31:0] MN_R    = 32'h00000000;
`else
  localparam logic [31:0] MULT_HI = 32'h00000006;
  localparam logic [31:0] DIV_Q   = 32'h7FFFFFFC;
  localparam logic [31:0] DIV_R   = 32'h00000001;
  localparam logic [31:0] MN_Q    = 32'h00000000;
  localparam logic [31:0] MN_R    = 32'h80000000;
`endif

  muldiv_unit #(.n(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op at the next falling edge, then track it to done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit interfere, input logic [31:0] hold_hi);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (interfere) begin
      wr_hi = 1'b1; wr_data = 32'h0000BEEF;
    end
    @(posedge clk); #1;
    check({tag, " busy@E0"}, {31'd0, busy}, 32'd1);
    check({tag, " done@E0"}, {31'd0, done}, 32'd0);
    if (interfere) check({tag, " hi kept on start"}, hi, hold_hi);
    busy_cnt = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    a = $urandom; b = $urandom;
    cycles = 0;
    while (1) begin
      @(posedge clk); #1;
      cycles++;
      if (done || cycles >= 100) break;
      if (busy) busy_cnt++;
      if (interfere && cycles == 5) begin
        start = 1'b1; op = OP_DIVU; wr_lo = 1'b1; wr_hi = 1'b1; wr_data = 32'h0000DEAD;
      end else if (interfere && cycles == 6) begin
        start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
      end
    end
    check({tag, " latency"}, cycles, 33);
    check({tag, " busy cycles"}, busy_cnt, 33);
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = OP_MULTU; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
    #1;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, '0);
    run_op("mult -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, MULT_HI, 32'hFFFFFFEB, 1'b0, '0);
    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, '0);
    run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_R, DIV_Q, 1'b0, '0);
    run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0, '0);
    run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, MN_R, MN_Q, 1'b0, '0);
    run_op("div -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, '0);

    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h00001234;
    @(posedge clk); #1;
    check("mthi hi", hi, 32'h00001234);
    check("mthi lo kept", lo, 32'hFFFFFFFF);
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hAAAA0001;
    @(posedge clk); #1;
    check("mthi+mtlo hi", hi, 32'hAAAA0001);
    check("mthi+mtlo lo", lo, 32'hAAAA0001);
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;

    run_op("busy ignore", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, 32'hAAAA0001);

    @(negedge clk);
    op = OP_MULTU; a = 32'h12345678; b = 32'h00000100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post-rst 3*4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, '0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
